// File: rtl/adc_spi_seq_pkg.sv
// adc_spi_seq_pkg: shared state encoding and width helpers for the ADC03 sequencer
package adc_spi_seq_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, MCU} state_t;
  localparam int MISSED_W = 8;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adc_spi_sequencer_shift.sv
// spi_shift_engine: SCLK divider, bit counter and MOSI/MISO shift registers for one frame
module spi_shift_engine
  import adc_spi_seq_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FRAME_BITS = 24,
  parameter int RES_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] cmd,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  done,
  output logic [RES_BITS-1:0]   result
);
  localparam int DW = cnt_w(2 * CLK_DIV);
  localparam int BW = cnt_w(FRAME_BITS);
  logic                  active;
  logic [DW-1:0]         div;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] tx;
  logic                  rise;
  logic                  bit_end;
  assign rise    = active && div == DW'(CLK_DIV);
  assign bit_end = active && div == DW'(2 * CLK_DIV - 1);
  assign done    = bit_end && bit_cnt == BW'(FRAME_BITS - 1);
  assign sclk    = active && div >= DW'(CLK_DIV);
  assign mosi    = active && tx[FRAME_BITS-1];
  // only the trailing RES_BITS MISO bits are kept, so the result register doubles as the RX shifter
  always_ff @(posedge clk)
    if (rst) begin
      active  <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      result  <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div     <= '0;
      bit_cnt <= '0;
      tx      <= cmd;
    end else if (active) begin
      div <= bit_end ? '0 : div + 1'b1;
      if (rise) result <= {result[RES_BITS-2:0], miso};
      if (bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
        tx      <= {tx[FRAME_BITS-2:0], 1'b0};
      end
      if (done) active <= 1'b0;
    end
endmodule

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: periodic ADC03 SPI sampler with MCU bus arbitration
module adc_spi_sequencer
  import adc_spi_seq_pkg::*;
#(
  parameter int                    CLK_DIV    = 4,
  parameter int                    FRAME_BITS = 24,
  parameter int                    PERIOD     = 1000,
  parameter int                    RES_BITS   = 12,
  parameter logic [FRAME_BITS-1:0] CMD        = 24'h060000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mcu_req,
  output logic                mcu_grant,
  output logic                spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [RES_BITS-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic [MISSED_W-1:0] missed
);
  localparam int PW = cnt_w(PERIOD);
  localparam int HW = cnt_w(CLK_DIV);
  state_t              state;
  state_t              nxt;
  logic [PW-1:0]       cnt;
  logic [HW-1:0]       ph;
  logic                tick;
  logic                ph_end;
  logic                start;
  logic                done;
  logic                frame_end;
  logic                eng_sclk;
  logic                eng_mosi;
  logic [RES_BITS-1:0] result;
  if (RES_BITS > FRAME_BITS) begin : g_res_check
    $error("RES_BITS must not exceed FRAME_BITS");
  end
  assign tick      = enable && cnt == PW'(PERIOD - 1);
  assign ph_end    = ph == HW'(CLK_DIV - 1);
  assign start     = state == CS_SETUP && ph_end;
  assign frame_end = state == CS_HOLD && ph_end;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = mcu_req ? MCU : tick ? CS_SETUP : IDLE;
      CS_SETUP: nxt = ph_end ? SHIFT : CS_SETUP;
      SHIFT:    nxt = done ? CS_HOLD : SHIFT;
      CS_HOLD:  nxt = ph_end ? GAP : CS_HOLD;
      GAP:      nxt = !ph_end ? GAP : mcu_req ? MCU : IDLE;
      MCU:      nxt = mcu_req ? MCU : GAP;
      default:  nxt = IDLE;
    endcase
  end
  // ph restarts on every state change so each timed phase lasts exactly CLK_DIV cycles
  always_ff @(posedge clk)
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ph           <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      missed       <= '0;
    end else begin
      state        <= nxt;
      ph           <= nxt != state ? '0 : ph + 1'b1;
      cnt          <= (!enable || tick) ? '0 : cnt + 1'b1;
      sample_valid <= frame_end;
      if (frame_end) sample <= result;
      if (tick && (state != IDLE || mcu_req) && missed != '1) missed <= missed + 1'b1;
    end
  assign mcu_grant = state == MCU;
  assign busy      = state != IDLE && state != MCU;
  assign spi_cs_n  = !(state inside {CS_SETUP, SHIFT, CS_HOLD});
  assign spi_sclk  = state == SHIFT && eng_sclk;
  assign spi_mosi  = state == CS_SETUP ? CMD[FRAME_BITS-1] : state == SHIFT && eng_mosi;
  spi_shift_engine #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .RES_BITS  (RES_BITS)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cmd   (CMD),
    .miso  (spi_miso),
    .sclk  (eng_sclk),
    .mosi  (eng_mosi),
    .done  (done),
    .result(result)
  );
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: table rows, corner sequences and random run against a timing-offset reference model
module tb_adc_spi_sequencer;
  localparam int PERIOD = 1000;
  logic clk = 0, rst = 1, enable = 0, mcu_req = 0, spi_miso = 0;
  logic mcu_grant, spi_cs_n, spi_sclk, spi_mosi, sample_valid, busy;
  logic [11:0] sample;
  logic [7:0] missed;
  int checks = 0, errors = 0;

  adc_spi_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .mcu_req(mcu_req), .mcu_grant(mcu_grant),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is described by its tick cycle t0; pins follow from the offset.
  typedef enum {M_IDLE, M_FRAME, M_MCU, M_GAP} mode_t;
  mode_t mode = M_IDLE;
  int pc = 0, t0 = 0, rcyc = 0, off;
  logic [7:0] m_missed = 0;
  logic [11:0] m_sample = 0;
  logic [23:0] cur_word = 0, cmd_v = 24'h060000;
  bit force_a5c = 0;
  logic m_tick;
  assign m_tick = enable && pc == PERIOD - 1;
  assign off = rcyc - t0;

  always @(posedge clk)
    if (rst) begin
      mode <= M_IDLE; pc <= 0; m_missed <= 0; m_sample <= 0; rcyc <= 0;
    end else begin
      pc <= (!enable || m_tick) ? 0 : pc + 1;
      rcyc <= rcyc + 1;
      if (m_tick && (mode != M_IDLE || mcu_req) && m_missed != 8'hFF) m_missed <= m_missed + 1;
      case (mode)
        M_IDLE:
          if (mcu_req) mode <= M_MCU;
          else if (m_tick) begin
            mode <= M_FRAME; t0 <= rcyc;
            cur_word <= {12'($urandom), force_a5c ? 12'hA5C : 12'($urandom)};
          end
        M_FRAME: begin
          if (off == 200) m_sample <= cur_word[11:0];
          if (off == 204) mode <= mcu_req ? M_MCU : M_IDLE;
        end
        M_MCU: if (!mcu_req) begin mode <= M_GAP; t0 <= rcyc + 1; end
        M_GAP: if (off == 3) mode <= mcu_req ? M_MCU : M_IDLE;
      endcase
    end

  function automatic logic [25:0] expect_out();
    logic cs = 1, sc = 0, mo = 0;
    if (mode == M_FRAME && off <= 200) begin
      cs = 0;
      if (off <= 4) mo = cmd_v[23];
      else if (off <= 196) begin
        mo = cmd_v[23 - (off - 5) / 8];
        sc = ((off - 5) % 8) >= 4;
      end
    end
    return {cs, sc, mo, mode == M_FRAME && off == 201, mode == M_FRAME || mode == M_GAP,
            mode == M_MCU, m_sample, m_missed};
  endfunction

  // ADC03 slave model plus event monitor
  bit chk_on = 0;
  logic prev_cs = 1, prev_sclk = 0, prev_grant = 0;
  logic [23:0] sh = 0, mcap = 0;
  int nbits = 0, rises = 0, sv_cnt = 0, sv_at = 0, csfalls = 0, csfall_at = 0, bad_grant = 0;
  always @(negedge clk)
    if (chk_on) begin
      check("outputs", {spi_cs_n, spi_sclk, spi_mosi, sample_valid, busy, mcu_grant, sample, missed},
            expect_out());
      if (prev_cs && !spi_cs_n) begin
        csfalls++; csfall_at = rcyc; sh = cur_word; spi_miso = sh[23]; mcap = 0; nbits = 0; rises = 0;
      end
      if (!spi_cs_n && prev_sclk && !spi_sclk) begin sh = sh << 1; spi_miso = sh[23]; end
      if (!spi_cs_n && !prev_sclk && spi_sclk) begin mcap = {mcap[22:0], spi_mosi}; nbits++; rises++; end
      if (sample_valid) begin
        sv_cnt++; sv_at = rcyc;
        check("mosi_word", {nbits[7:0], mcap}, {8'd24, cmd_v});
      end
      if (mcu_grant && !spi_cs_n) bad_grant++;
      prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_grant = mcu_grant;
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic req);
    rst = 1;
    step();
    rst = 0; enable = en; mcu_req = req; sv_cnt = 0; csfalls = 0;
  endtask

  typedef struct {
    logic en; logic req; int n; int exp_sv; int exp_missed; logic exp_grant;
  } row_t;
  row_t rows[5];

  initial begin
    int t_en;
    rows[0] = '{1'b1, 1'b0, 1201, 1, 0, 1'b0};
    rows[1] = '{1'b1, 1'b0, 5201, 5, 0, 1'b0};
    rows[2] = '{1'b1, 1'b1, 3500, 0, 3, 1'b1};
    rows[3] = '{1'b0, 1'b0, 3000, 0, 0, 1'b0};
    rows[4] = '{1'b1, 1'b1, 4000, 0, 4, 1'b1};
    step();
    chk_on = 1;
    do_reset(0, 0);
    check("reset_state", {spi_cs_n, spi_sclk, spi_mosi, sample_valid, busy, mcu_grant, sample, missed},
          {1'b1, 25'd0});
    foreach (rows[i]) begin
      do_reset(rows[i].en, rows[i].req);
      repeat (rows[i].n) step();
      check($sformatf("row%0d_valids", i), sv_cnt, rows[i].exp_sv);
      check($sformatf("row%0d_missed", i), missed, rows[i].exp_missed);
      check($sformatf("row%0d_grant", i), mcu_grant, rows[i].exp_grant);
    end
    // tick-to-valid latency and captured result
    force_a5c = 1;
    do_reset(1, 0);
    for (int i = 0; i < 1300 && sv_cnt == 0; i++) step();
    check("lat_valid", sv_cnt, 1);
    check("latency", sv_at - (csfall_at - 1), 201);
    check("lat_abs", sv_at, 1200);
    check("lat_sample", sample, 12'hA5C);
    force_a5c = 0;
    // mcu_req mid-frame waits for the gap
    do_reset(1, 0);
    for (int i = 0; i < 1300 && !(spi_cs_n == 0 && rises >= 10); i++) step();
    mcu_req = 1;
    for (int i = 0; i < 400 && !mcu_grant; i++) step();
    check("grant_rise", mcu_grant, 1);
    check("grant_after_gap", rcyc - sv_at, 4);
    check("grant_frame_sample", sv_cnt, 1);
    repeat (50) step();
    mcu_req = 0;
    step();
    check("grant_release", mcu_grant, 0);
    // reset mid-shift
    do_reset(1, 0);
    for (int i = 0; i < 1300 && !spi_sclk; i++) step();
    check("sclk_seen", spi_sclk, 1);
    rst = 1;
    step();
    check("rst_midframe", {spi_cs_n, spi_sclk, spi_mosi, sample_valid, busy, mcu_grant, sample, missed},
          {1'b1, 25'd0});
    rst = 0; sv_cnt = 0;
    repeat (300) step();
    check("rst_no_valid", sv_cnt, 0);
    // enable dropped mid-frame
    do_reset(1, 0);
    for (int i = 0; i < 1300 && spi_cs_n; i++) step();
    check("frame_started", spi_cs_n, 0);
    enable = 0; sv_cnt = 0;
    for (int i = 0; i < 300 && sv_cnt == 0; i++) step();
    check("en_drop_valid", sv_cnt, 1);
    check("en_drop_sample", sample, cur_word[11:0]);
    csfalls = 0;
    repeat (2000) step();
    check("en_off_frames", csfalls, 0);
    enable = 1; t_en = rcyc;
    for (int i = 0; i < 1100 && csfalls == 0; i++) step();
    check("en_first_tick", csfall_at - t_en, 1000);
    // random traffic against the model
    do_reset(1, 0);
    repeat (25000) begin
      if ($urandom_range(0, 599) == 0) mcu_req = ~mcu_req;
      if ($urandom_range(0, 2499) == 0) enable = ~enable;
      rst = $urandom_range(0, 9999) == 0;
      step();
    end
    rst = 0;
    step();
    check("grant_cs_overlap", bad_grant, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
